// File: rtl/reg_bank.sv
// reg_bank: multi-entry register bank with one write port and two registered
// read ports. A soft clear walks every entry to zero, one entry per enabled edge.
// Entry 0 can be hard-wired to zero. Same-edge write data can be forwarded to
// the read ports.
module reg_bank #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr,
  input  logic [ADDR_W-1:0] wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd,
  input  logic [ADDR_W-1:0] rd_sel_a,
  input  logic [ADDR_W-1:0] rd_sel_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid,
  input  logic              clr,
  output logic              busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              do_wr;
  logic              do_rd;
  logic              do_clr_wr;
  logic [DATA_W-1:0] rd_next_a;
  logic [DATA_W-1:0] rd_next_b;

  // Next-state and per-edge action decode; nothing happens while en=0.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    do_wr     = 1'b0;
    do_rd     = 1'b0;
    do_clr_wr = 1'b0;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (clr) begin
            state_d = CLEAR;
            cnt_d   = '0;
          end else begin
            do_wr = wr;
            do_rd = rd;
          end
        end
        CLEAR: begin
          do_clr_wr = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and clear-walk counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == CLEAR);

  // Read-side mux: the hard zero wins over bypass, bypass wins over storage.
  always_comb begin
    rd_next_a = mem[rd_sel_a];
    rd_next_b = mem[rd_sel_b];
    if (BYPASS != 0 && do_wr && wr_sel == rd_sel_a) begin
      rd_next_a = wr_data;
    end
    if (BYPASS != 0 && do_wr && wr_sel == rd_sel_b) begin
      rd_next_b = wr_data;
    end
    if (ZERO_REG != 0 && rd_sel_a == '0) begin
      rd_next_a = '0;
    end
    if (ZERO_REG != 0 && rd_sel_b == '0) begin
      rd_next_b = '0;
    end
  end

  // Storage: the clear walk and host writes are mutually exclusive by state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_clr_wr) begin
      mem[cnt_q] <= '0;
    end else if (do_wr && !(ZERO_REG != 0 && wr_sel == '0)) begin
      mem[wr_sel] <= wr_data;
    end
  end

  // Registered read ports; data holds unless a read is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
      rd_valid  <= 1'b0;
    end else if (en) begin
      rd_valid <= do_rd;
      if (do_rd) begin
        rd_data_a <= rd_next_a;
        rd_data_b <= rd_next_b;
      end
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: three instances share one stimulus stream --
// default (bypass on), bypass off, and entry 0 hard-wired to zero.
module tb_reg_bank;

  logic        clk;
  logic        rst;
  logic        en;
  logic        wr;
  logic [3:0]  wr_sel;
  logic [31:0] wr_data;
  logic        rd;
  logic [3:0]  rd_sel_a;
  logic [3:0]  rd_sel_b;
  logic        clr;

  logic [31:0] a0, b0, a1, b1, a2, b2;
  logic        v0, v1, v2;
  logic        busy0, busy1, busy2;

  int vectors    = 0;
  int miscompares = 0;
  int n;

  reg_bank #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd(rd), .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
    .rd_data_a(a0), .rd_data_b(b0), .rd_valid(v0), .clr(clr), .busy(busy0)
  );

  reg_bank #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0)) dut_nobyp (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd(rd), .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
    .rd_data_a(a1), .rd_data_b(b1), .rd_valid(v1), .clr(clr), .busy(busy1)
  );

  reg_bank #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) dut_zero (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd(rd), .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
    .rd_data_a(a2), .rd_data_b(b2), .rd_valid(v2), .clr(clr), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr = 1'b0; rd = 1'b0; clr = 1'b0;
    wr_sel = '0; wr_data = '0; rd_sel_a = '0; rd_sel_b = '0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0;
    idle_inputs();
    #2;
    // Reset state
    check("rst_a", a0, 32'h0);
    check("rst_b", b0, 32'h0);
    check("rst_valid", {31'b0, v0}, 32'h0);
    check("rst_busy", {31'b0, busy0}, 32'h0);
    step(); step();
    rst = 1'b0; en = 1'b1;

    // Write 0xDEADBEEF to 5, then read a=5 b=3
    wr = 1'b1; wr_sel = 4'd5; wr_data = 32'hDEADBEEF;
    step();
    check("wr_no_valid", {31'b0, v0}, 32'h0);
    wr = 1'b0; rd = 1'b1; rd_sel_a = 4'd5; rd_sel_b = 4'd3;
    step();
    check("rd5_a", a0, 32'hDEADBEEF);
    check("rd3_b", b0, 32'h0);
    check("rd_valid_1", {31'b0, v0}, 32'h1);
    rd = 1'b0;
    step();
    check("rd_valid_drop", {31'b0, v0}, 32'h0);
    check("rd_hold_a", a0, 32'hDEADBEEF);

    // Same-edge write 0x12345678 to 7 with read a=7 b=5
    wr = 1'b1; wr_sel = 4'd7; wr_data = 32'h12345678;
    rd = 1'b1; rd_sel_a = 4'd7; rd_sel_b = 4'd5;
    step();
    check("byp_on_a", a0, 32'h12345678);
    check("byp_off_a", a1, 32'h0);
    check("byp_off_b", b1, 32'hDEADBEEF);
    wr = 1'b0;
    step();
    check("byp_off_after", a1, 32'h12345678);

    // Hard-wired entry 0: write all ones with same-edge read, then plain read
    wr = 1'b1; wr_sel = 4'd0; wr_data = 32'hFFFFFFFF;
    rd = 1'b1; rd_sel_a = 4'd0; rd_sel_b = 4'd7;
    step();
    check("zero_byp_a", a2, 32'h0);
    check("zero_byp_b", b2, 32'h12345678);
    check("nz_byp_a", a0, 32'hFFFFFFFF);
    wr = 1'b0;
    step();
    check("zero_rd_a", a2, 32'h0);
    check("nz_rd_a", a0, 32'hFFFFFFFF);

    // Fill all 16 entries with 0x100+i
    rd = 1'b0; wr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_sel = 4'(i); wr_data = 32'h100 + 32'(i);
      step();
    end
    wr = 1'b0; rd = 1'b1; rd_sel_a = 4'd15; rd_sel_b = 4'd9;
    step();
    check("fill_a15", a0, 32'h10F);
    check("fill_b9", b0, 32'h109);
    rd = 1'b0;

    // Clear walk: writes and reads issued while busy must be dropped
    clr = 1'b1;
    step();
    check("clr_busy", {31'b0, busy0}, 32'h1);
    clr = 1'b0;
    wr = 1'b1; wr_sel = 4'd0; wr_data = 32'h0BAD0BAD;
    rd = 1'b1; rd_sel_a = 4'd15; rd_sel_b = 4'd9;
    n = 0;
    while (busy0 && n < 40) begin
      check("walk_no_valid", {31'b0, v0}, 32'h0);
      step();
      n++;
    end
    idle_inputs();
    check("walk_len", 32'(n), 32'd16);
    check("walk_hold_a", a0, 32'h10F);
    rd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_sel_a = 4'(i); rd_sel_b = 4'(i + 8);
      step();
      check("clr_a", a0, 32'h0);
      check("clr_b", b0, 32'h0);
    end
    rd = 1'b0;

    // Clear walk with en=0 for three cycles in the middle
    clr = 1'b1;
    step();
    clr = 1'b0;
    n = 0;
    repeat (5) begin step(); n++; end
    en = 1'b0;
    repeat (3) step();
    check("frozen_busy", {31'b0, busy0}, 32'h1);
    en = 1'b1;
    while (busy0 && n < 40) begin step(); n++; end
    check("walk_en_len", 32'(n), 32'd16);

    // Reset asserted between edges in the middle of a walk
    wr = 1'b1; wr_sel = 4'd2; wr_data = 32'h55;
    step();
    wr = 1'b0; rd = 1'b1; rd_sel_a = 4'd2; rd_sel_b = 4'd2;
    step();
    check("pre_rst_a", a0, 32'h55);
    rd = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    step(); step();
    #2;
    rst = 1'b1;
    #1;
    check("async_busy", {31'b0, busy0}, 32'h0);
    check("async_a", a0, 32'h0);
    check("async_b", b0, 32'h0);
    step();
    rst = 1'b0;

    // Normal operation after reset; earlier contents are gone
    wr = 1'b1; wr_sel = 4'd2; wr_data = 32'h77;
    rd = 1'b1; rd_sel_a = 4'd9; rd_sel_b = 4'd2;
    step();
    check("post_rst_valid", {31'b0, v0}, 32'h1);
    check("post_rst_a9", a0, 32'h0);
    check("post_rst_byp", b0, 32'h77);
    idle_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
